// File: rtl/hazard_forward_ctrl.sv
// Scoreboard-based operand forwarding and stall control for the in-order pipeline.
// Tracks in-flight destinations over PIPE_DEPTH stages and steers EX and ID-compare operand muxes.
module hazard_forward_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PIPE_DEPTH     = 4,
  parameter int LOAD_LAT       = 2,
  parameter int SEL_WIDTH      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic                      id_is_branch,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_wr_en,
  input  logic                      id_is_load,
  input  logic                      flush,
  output logic                      stall_id,
  output logic [SEL_WIDTH-1:0]      ex_fwd_sel1,
  output logic [SEL_WIDTH-1:0]      ex_fwd_sel2,
  output logic [SEL_WIDTH-1:0]      id_cmp_sel1,
  output logic [SEL_WIDTH-1:0]      id_cmp_sel2
);

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  localparam int ALU_READY_STAGE  = 32'sd2;
  localparam int LOAD_READY_STAGE = LOAD_LAT + 32'sd1;

  logic [PIPE_DEPTH:1]        sb_v_r;
  logic [PIPE_DEPTH:1]        sb_ld_r;
  reg_addr_t [PIPE_DEPTH:1]   sb_rd_r;

  logic [SEL_WIDTH-1:0] ex_sel1_s, ex_sel2_s, cmp_sel1_s, cmp_sel2_s;
  logic                 ex_haz1_s, ex_haz2_s, cmp_haz1_s, cmp_haz2_s;
  logic                 haz1_s, haz2_s, stall_s, issue_s, ins_v_s;
  logic [SEL_WIDTH-1:0] ex_sel1_nxt_s, ex_sel2_nxt_s;
  logic [SEL_WIDTH-1:0] cmp_out1_s, cmp_out2_s;
  logic [SEL_WIDTH-1:0] ex_sel1_r, ex_sel2_r;

  // A producer's result exists on a bypass path once it reaches its ready stage.
  function automatic logic stage_ready(input int stage, input logic is_load);
    logic rdy;
    if (is_load) begin
      rdy = (stage >= LOAD_READY_STAGE);
    end else begin
      rdy = (stage >= ALU_READY_STAGE);
    end
    return rdy;
  endfunction

  // Youngest-match lookup for one source, resolved both for EX use (one stage later) and ID compare (now).
  function automatic void eval_src(
    input  logic [PIPE_DEPTH:1]      v,
    input  logic [PIPE_DEPTH:1]      ld,
    input  reg_addr_t [PIPE_DEPTH:1] rd,
    input  reg_addr_t                r,
    output logic [SEL_WIDTH-1:0]     ex_sel,
    output logic                     ex_haz,
    output logic [SEL_WIDTH-1:0]     cmp_sel,
    output logic                     cmp_haz
  );
    int   young;
    logic young_ld;
    young    = 32'sd0;
    young_ld = 1'b0;
    ex_sel   = '0;
    ex_haz   = 1'b0;
    cmp_sel  = '0;
    cmp_haz  = 1'b0;
    // Scan oldest to youngest so the smallest matching stage is left standing.
    for (int k = PIPE_DEPTH; k >= 32'sd1; k--) begin
      if (v[k] && (rd[k] == r) && (r != '0)) begin
        young    = k;
        young_ld = ld[k];
      end else begin
        young    = young;
        young_ld = young_ld;
      end
    end
    if (young == 32'sd0) begin
      ex_sel  = '0;
      cmp_sel = '0;
    end else begin
      if (young >= PIPE_DEPTH) begin
        ex_sel = '0;
      end else if (stage_ready(young + 32'sd1, young_ld)) begin
        ex_sel = SEL_WIDTH'(young + 32'sd1);
      end else begin
        ex_haz = 1'b1;
      end
      if (stage_ready(young, young_ld)) begin
        cmp_sel = SEL_WIDTH'(young);
      end else begin
        cmp_haz = 1'b1;
      end
    end
  endfunction

  // Per-source match resolution against the current scoreboard.
  always_comb begin
    eval_src(sb_v_r, sb_ld_r, sb_rd_r, id_rs1, ex_sel1_s, ex_haz1_s, cmp_sel1_s, cmp_haz1_s);
    eval_src(sb_v_r, sb_ld_r, sb_rd_r, id_rs2, ex_sel2_s, ex_haz2_s, cmp_sel2_s, cmp_haz2_s);
  end

  // Hazard, stall and issue decisions; flush overrides any stall.
  always_comb begin
    haz1_s  = 1'b0;
    haz2_s  = 1'b0;
    if (id_use_rs1) begin
      haz1_s = id_is_branch ? cmp_haz1_s : ex_haz1_s;
    end else begin
      haz1_s = 1'b0;
    end
    if (id_use_rs2) begin
      haz2_s = id_is_branch ? cmp_haz2_s : ex_haz2_s;
    end else begin
      haz2_s = 1'b0;
    end
    stall_s = id_valid && !flush && (haz1_s || haz2_s);
    issue_s = id_valid && !flush && !stall_s;
    ins_v_s = issue_s && id_reg_wr_en && (id_rd != '0);
  end

  // EX selects for the instruction about to enter EX; bubbles and branches take the regfile path.
  always_comb begin
    ex_sel1_nxt_s = '0;
    ex_sel2_nxt_s = '0;
    if (issue_s && !id_is_branch) begin
      ex_sel1_nxt_s = id_use_rs1 ? ex_sel1_s : '0;
      ex_sel2_nxt_s = id_use_rs2 ? ex_sel2_s : '0;
    end else begin
      ex_sel1_nxt_s = '0;
      ex_sel2_nxt_s = '0;
    end
  end

  // ID branch-compare selects, live only for a valid branch whose producer is ready.
  always_comb begin
    cmp_out1_s = '0;
    cmp_out2_s = '0;
    if (id_valid && id_is_branch) begin
      cmp_out1_s = (id_use_rs1 && !cmp_haz1_s) ? cmp_sel1_s : '0;
      cmp_out2_s = (id_use_rs2 && !cmp_haz2_s) ? cmp_sel2_s : '0;
    end else begin
      cmp_out1_s = '0;
      cmp_out2_s = '0;
    end
  end

  // Scoreboard shift: ID inserts at stage 1, the oldest entry retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v_r  <= '0;
      sb_ld_r <= '0;
      sb_rd_r <= '0;
    end else begin
      for (int k = PIPE_DEPTH; k >= 32'sd2; k--) begin
        sb_v_r[k]  <= sb_v_r[k-1];
        sb_ld_r[k] <= sb_ld_r[k-1];
        sb_rd_r[k] <= sb_rd_r[k-1];
      end
      sb_v_r[1]  <= ins_v_s;
      sb_ld_r[1] <= ins_v_s ? id_is_load : 1'b0;
      sb_rd_r[1] <= ins_v_s ? id_rd : '0;
    end
  end

  // Registered EX operand selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_sel1_r <= '0;
      ex_sel2_r <= '0;
    end else begin
      ex_sel1_r <= ex_sel1_nxt_s;
      ex_sel2_r <= ex_sel2_nxt_s;
    end
  end

  assign stall_id    = stall_s;
  assign ex_fwd_sel1 = ex_sel1_r;
  assign ex_fwd_sel2 = ex_sel2_r;
  assign id_cmp_sel1 = cmp_out1_s;
  assign id_cmp_sel2 = cmp_out2_s;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed pipeline scenarios plus random
// traffic checked against a cycle-history model of in-flight producers.
module tb_hazard_forward_ctrl;
  localparam int RW = 5;
  localparam int PD = 4;
  localparam int LL = 2;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_is_branch = 1'b0;
  logic          id_reg_wr_en = 1'b0, id_is_load = 1'b0, flush = 1'b0;
  logic          stall_id;
  logic [SW-1:0] ex_fwd_sel1, ex_fwd_sel2, id_cmp_sel1, id_cmp_sel2;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_ADDR_WIDTH(RW), .PIPE_DEPTH(PD), .LOAD_LAT(LL), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_branch(id_is_branch),
    .id_rd(id_rd), .id_reg_wr_en(id_reg_wr_en), .id_is_load(id_is_load), .flush(flush),
    .stall_id(stall_id), .ex_fwd_sel1(ex_fwd_sel1), .ex_fwd_sel2(ex_fwd_sel2),
    .id_cmp_sel1(id_cmp_sel1), .id_cmp_sel2(id_cmp_sel2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 16;

  // History of what left ID in each cycle; the entry from k cycles ago sits in stage k.
  logic          lv [64];
  logic [RW-1:0] lrd [64];
  logic          lld [64];

  logic          exp_stall, obs_stall;
  logic [SW-1:0] exp_cmp1, exp_cmp2, obs_cmp1, obs_cmp2;
  logic [SW-1:0] exp_ex1, exp_ex2, obs_ex1, obs_ex2;

  function automatic logic ready_at(input int stage, input logic is_load);
    return is_load ? (stage >= LL + 1) : (stage >= 2);
  endfunction

  task automatic clear_log();
    for (int i = 0; i < 64; i++) begin
      lv[i] = 1'b0; lrd[i] = '0; lld[i] = 1'b0;
    end
  endtask

  task automatic model_src(input logic [RW-1:0] r, input logic use_r, input logic br,
                           output int ex_sel, output int cmp_sel, output logic haz);
    int hit;
    int idx;
    hit = 0; ex_sel = 0; cmp_sel = 0; haz = 1'b0;
    if (use_r && r != 0) begin
      for (int k = 1; k <= PD; k++) begin
        idx = (cyc - k) % 64;
        if (hit == 0 && lv[idx] && lrd[idx] == r) hit = k;
      end
    end
    if (hit != 0) begin
      idx = (cyc - hit) % 64;
      if (br) begin
        if (ready_at(hit, lld[idx])) cmp_sel = hit; else haz = 1'b1;
      end else begin
        if (hit == PD) ex_sel = 0;
        else if (ready_at(hit + 1, lld[idx])) ex_sel = hit + 1;
        else haz = 1'b1;
      end
    end
  endtask

  task automatic drive_cycle(input logic v, input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                             input logic u1, input logic u2, input logic br,
                             input logic [RW-1:0] rd, input logic wr, input logic ld, input logic fl);
    int   e1, e2, c1, c2;
    logic h1, h2, iss;
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_is_branch = br; id_rd = rd; id_reg_wr_en = wr; id_is_load = ld; flush = fl;
    #1;
    model_src(r1, u1, br, e1, c1, h1);
    model_src(r2, u2, br, e2, c2, h2);
    exp_stall = v && !fl && (h1 || h2);
    iss = v && !fl && !exp_stall;
    exp_cmp1 = (v && br) ? SW'(c1) : '0;
    exp_cmp2 = (v && br) ? SW'(c2) : '0;
    exp_ex1 = (iss && !br) ? SW'(e1) : '0;
    exp_ex2 = (iss && !br) ? SW'(e2) : '0;
    obs_stall = stall_id; obs_cmp1 = id_cmp_sel1; obs_cmp2 = id_cmp_sel2;
    @(posedge clk);
    lv[cyc % 64] = iss && wr && (rd != 0);
    lrd[cyc % 64] = rd;
    lld[cyc % 64] = ld;
    cyc++;
    #1;
    obs_ex1 = ex_fwd_sel1; obs_ex2 = ex_fwd_sel2;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < PD + 1; i++) drive_cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd6; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_is_branch = 1'b1;
    #1;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_id); end
    total++; if (ex_fwd_sel1 !== 3'd0 || ex_fwd_sel2 !== 3'd0) begin bad++; $display("FAIL reset_ex: got %0d/%0d want 0/0", ex_fwd_sel1, ex_fwd_sel2); end
    total++; if (id_cmp_sel1 !== 3'd0 || id_cmp_sel2 !== 3'd0) begin bad++; $display("FAIL reset_cmp: got %0d/%0d want 0/0", id_cmp_sel1, id_cmp_sel2); end
    @(negedge clk);
    id_valid = 1'b0;
    clear_log();
    rst_n = 1'b1;
  endtask

  task automatic test_alu_chain();
    drain();
    drive_cycle(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %0d want 0", obs_stall); end
    total++; if (obs_ex1 !== 3'd2 || obs_ex2 !== 3'd0) begin bad++; $display("FAIL alu_fwd: got %0d/%0d want 2/0", obs_ex1, obs_ex2); end
    drain();
    drive_cycle(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    total++; if (obs_stall !== 1'b0 || obs_ex1 !== 3'd3) begin bad++; $display("FAIL alu_gap: stall=%0d sel=%0d want 0/3", obs_stall, obs_ex1); end
  endtask

  task automatic test_load_use();
    drain();
    drive_cycle(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    drive_cycle(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    total++; if (obs_stall !== 1'b1) begin bad++; $display("FAIL lu_stall1: got %0d want 1", obs_stall); end
    total++; if (obs_ex1 !== 3'd0 || obs_ex2 !== 3'd0) begin bad++; $display("FAIL lu_bubble: got %0d/%0d want 0/0", obs_ex1, obs_ex2); end
    drive_cycle(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL lu_stall2: got %0d want 0", obs_stall); end
    total++; if (obs_ex1 !== 3'd3 || obs_ex2 !== 3'd3) begin bad++; $display("FAIL lu_fwd: got %0d/%0d want 3/3", obs_ex1, obs_ex2); end
  endtask

  task automatic test_load_branch();
    drain();
    drive_cycle(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      total++; if (obs_stall !== 1'b1) begin bad++; $display("FAIL lb_stall%0d: got %0d want 1", i, obs_stall); end
    end
    drive_cycle(1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL lb_release: got %0d want 0", obs_stall); end
    total++; if (obs_cmp1 !== 3'd3 || obs_cmp2 !== 3'd0) begin bad++; $display("FAIL lb_cmp: got %0d/%0d want 3/0", obs_cmp1, obs_cmp2); end
  endtask

  task automatic test_priority_x0();
    drain();
    drive_cycle(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
    total++; if (obs_stall !== 1'b0 || obs_ex1 !== 3'd2) begin bad++; $display("FAIL prio: stall=%0d sel=%0d want 0/2", obs_stall, obs_ex1); end
    drive_cycle(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    drive_cycle(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
    total++; if (obs_stall !== 1'b0 || obs_ex1 !== 3'd0 || obs_ex2 !== 3'd0) begin bad++; $display("FAIL x0_alu: stall=%0d sel=%0d/%0d want 0/0/0", obs_stall, obs_ex1, obs_ex2); end
    drive_cycle(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    total++; if (obs_stall !== 1'b0 || obs_cmp1 !== 3'd0) begin bad++; $display("FAIL x0_br: stall=%0d cmp=%0d want 0/0", obs_stall, obs_cmp1); end
  endtask

  task automatic test_flush();
    drain();
    drive_cycle(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    drive_cycle(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
    total++; if (obs_stall !== 1'b0 || obs_ex1 !== 3'd0) begin bad++; $display("FAIL flush_cut: stall=%0d sel=%0d want 0/0", obs_stall, obs_ex1); end
    drive_cycle(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    total++; if (obs_stall !== 1'b0 || obs_ex1 !== 3'd0) begin bad++; $display("FAIL flush_drop: stall=%0d sel=%0d want 0/0", obs_stall, obs_ex1); end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    drive_cycle(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    total++; if (obs_ex1 !== 3'd2) begin bad++; $display("FAIL rst_pre_fwd: got %0d want 2", obs_ex1); end
    id_valid = 1'b1; id_rs1 = 5'd7; id_rs2 = 5'd7; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_is_branch = 1'b0; id_rd = 5'd8; id_reg_wr_en = 1'b1; id_is_load = 1'b0; flush = 1'b0;
    #1;
    total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL rst_pre_stall: got %0d want 1", stall_id); end
    rst_n = 1'b0;
    #1;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL rst_async_stall: got %0d want 0", stall_id); end
    total++; if (ex_fwd_sel1 !== 3'd0 || ex_fwd_sel2 !== 3'd0) begin bad++; $display("FAIL rst_async_ex: got %0d/%0d want 0/0", ex_fwd_sel1, ex_fwd_sel2); end
    @(posedge clk);
    @(negedge clk);
    clear_log();
    rst_n = 1'b1;
    drive_cycle(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    total++; if (obs_stall !== 1'b0 || obs_ex1 !== 3'd0 || obs_ex2 !== 3'd0) begin bad++; $display("FAIL rst_reeval: stall=%0d sel=%0d/%0d want 0/0/0", obs_stall, obs_ex1, obs_ex2); end
  endtask

  task automatic test_random();
    logic v, u1, u2, br, wr, ld, fl;
    logic [RW-1:0] r1, r2, rd;
    drain();
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 7) != 0);
      r1 = RW'($urandom_range(0, 3));
      r2 = RW'($urandom_range(0, 3));
      rd = RW'($urandom_range(0, 3));
      u1 = ($urandom_range(0, 3) != 0);
      u2 = ($urandom_range(0, 1) != 0);
      br = ($urandom_range(0, 3) == 0);
      wr = br ? 1'b0 : ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 11) == 0);
      drive_cycle(v, r1, r2, u1, u2, br, rd, wr, ld, fl);
      total++; if (obs_stall !== exp_stall) begin bad++; $display("FAIL rnd_stall n=%0d: got %0d want %0d", n, obs_stall, exp_stall); end
      total++; if (obs_cmp1 !== exp_cmp1 || obs_cmp2 !== exp_cmp2) begin bad++; $display("FAIL rnd_cmp n=%0d: got %0d/%0d want %0d/%0d", n, obs_cmp1, obs_cmp2, exp_cmp1, exp_cmp2); end
      total++; if (obs_ex1 !== exp_ex1 || obs_ex2 !== exp_ex2) begin bad++; $display("FAIL rnd_ex n=%0d: got %0d/%0d want %0d/%0d", n, obs_ex1, obs_ex2, exp_ex1, exp_ex2); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_log();
    repeat (2) @(negedge clk);
    test_reset();
    test_alu_chain();
    test_load_use();
    test_load_branch();
    test_priority_x0();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
